// File: rtl/store_buffer.sv
// store_buffer: posted-write queue between the core data port and a multi-cycle data memory.
// Stores are accepted in one cycle, held in a circular FIFO and drained over a req/ack handshake.
// Loads read the memory's combinational port.
// Optional feature macro STBUF_FWD_EN: when defined, a load returns the youngest matching queued
// store. When undefined, there is no forwarding and a load stalls until the queue is empty.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] DataAdr,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          Empty,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e        state_q, state_d;
    logic [AW-3:0] adr_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH for free
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          empty_q;
    logic          full, push, pop;

    assign full      = (count_q == FULL_CNT);
    assign push      = MemWrite & ~Stall;
    assign pop       = (state_q == StReq) & mem_ack;
    assign Empty     = empty_q;
    assign mem_addr  = {adr_q[head_q], 2'b00};
    assign mem_wdata = dat_q[head_q];
    assign mem_raddr = DataAdr;

    // Next-state pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: look at the post-edge count so a store into an empty queue is requested next cycle
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_d != '0) state_d = StReq;
            end
            StReq: begin
                mem_req = 1'b1;
                if (count_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state; reset discards every queued store and drops mem_req at once
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    // Entry storage; contents only matter while counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail_q] <= DataAdr[AW-1:2];
            dat_q[tail_q] <= WriteData;
        end
    end

`ifdef STBUF_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest match wins; the entry being popped still counts
    always_comb begin
        ReadData = mem_rdata;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + i[PW-1:0];
            if (((PW + 1)'(i) < count_q) && (adr_q[fwd_idx] == DataAdr[AW-1:2])) begin
                ReadData = dat_q[fwd_idx];
            end
        end
    end

    assign Stall = MemWrite & full;
`else
    assign ReadData = mem_rdata;
    // Without forwarding a load must wait for the queue to drain
    assign Stall    = (MemWrite & full) | (MemRead & ~empty_q);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer with a scoreboard of expected memory
// writes. Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_store_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          MemWrite  = 1'b0;
    logic          MemRead   = 1'b0;
    logic [AW-1:0] DataAdr   = '0;
    logic [31:0]   WriteData = '0;
    logic          mem_ack   = 1'b0;
    logic [31:0]   ReadData;
    logic          Stall;
    logic          Empty;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          drained  = 0;
    logic [63:0] sb [$];
    logic [63:0] mon_exp;
    bit          rand_ack  = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_wdata;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Empty     (Empty),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    // Backing memory read port: a pattern derived from the read address
    assign mem_rdata = {mem_raddr[15:0], 16'hBEEF};

    always #5 clk = ~clk;

    // Random ack pattern, about 30% high, used only by the random drain scenario
    always @(posedge clk) begin
        if (rand_ack) begin
            #1;
            mem_ack = ($urandom_range(0, 99) < 30);
        end
    end

    // Memory-side monitor: req&ack seen here completes at the next rising edge
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && mem_req) begin
                chk_cnt++;
                if (mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
                    $display("FAIL stable_req: addr %h data %h, required addr %h data %h",
                             mem_addr, mem_wdata, prev_addr, prev_wdata);
                end else begin
                    pass_cnt++;
                end
            end
            if (mem_req && mem_ack) begin
                chk_cnt++;
                drained++;
                if (sb.size() == 0) begin
                    $display("FAIL drain_extra: addr %h data %h, required no request",
                             mem_addr, mem_wdata);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({mem_addr, mem_wdata} !== mon_exp) begin
                        $display("FAIL drain_order: addr %h data %h, required addr %h data %h",
                                 mem_addr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
                    end else begin
                        pass_cnt++;
                    end
                end
            end
            prev_hold  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a store until it is taken; leaves MemWrite high after the accepting edge
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        stalls    = 0;
        forever begin
            @(negedge clk);
            if (!Stall) begin
                sb.push_back({a[31:2], 2'b00, d});
                break;
            end
            stalls++;
            if (stalls > 100) begin
                chk_cnt++;
                $display("FAIL store_timeout: addr %h still stalled, required acceptance", a);
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n       = 0;
        mem_ack = 1'b1;
        @(negedge clk);
        while (!Empty && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (Empty !== 1'b1) $display("FAIL %s_empty: Empty %b, required 1", tag, Empty);
        else pass_cnt++;
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL %s_sb: %0d stores undrained, required 0", tag, sb.size());
        else pass_cnt++;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk_cnt++;
        if (mem_req !== 1'b0) $display("FAIL reset_req: mem_req %b, required 0", mem_req);
        else pass_cnt++;
        chk_cnt++;
        if (Empty !== 1'b1) $display("FAIL reset_empty: Empty %b, required 1", Empty);
        else pass_cnt++;
        chk_cnt++;
        if (Stall !== 1'b0) $display("FAIL reset_stall: Stall %b, required 0", Stall);
        else pass_cnt++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_store();
        int st;
        mem_ack = 1'b1;
        do_store(32'h64, 32'd7, st);
        MemWrite = 1'b0;
        chk_cnt++;
        if (st != 0) $display("FAIL single_stall: %0d stall cycles, required 0", st);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h64 || mem_wdata !== 32'd7)
            $display("FAIL single_req: req %b addr %h data %h, required 1 00000064 00000007",
                     mem_req, mem_addr, mem_wdata);
        else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++;
        if (Empty !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL single_empty: Empty %b req %b, required 1 0", Empty, mem_req);
        else pass_cnt++;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_full();
        int st;
        int tot;
        tot     = 0;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'(i * 4), 32'hA0 + 32'(i), st);
            tot += st;
        end
        chk_cnt++;
        if (tot != 0) $display("FAIL full_fill: %0d stall cycles, required 0", tot);
        else pass_cnt++;
        // Fifth store meets a full queue; the ack in the same cycle does not admit it
        DataAdr   = 32'h10;
        WriteData = 32'hA4;
        mem_ack   = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (Stall !== 1'b1) $display("FAIL full_stall: Stall %b, required 1", Stall);
        else pass_cnt++;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (Stall !== 1'b0) $display("FAIL full_admit: Stall %b, required 0", Stall);
        else pass_cnt++;
        sb.push_back({32'h10, 32'hA4});
        tick();
        MemWrite = 1'b0;
        wait_empty("full");
    endtask

    task automatic test_forward();
        int st;
        mem_ack = 1'b0;
        do_store(32'h60, 32'h11, st);
        do_store(32'h60, 32'h22, st);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        DataAdr  = 32'h60;
`ifdef STBUF_FWD_EN
        @(negedge clk);
        chk_cnt++;
        if (Stall !== 1'b0 || ReadData !== 32'h22)
            $display("FAIL fwd_hit: Stall %b data %h, required 0 00000022", Stall, ReadData);
        else pass_cnt++;
        tick();
        DataAdr = 32'h68;
        @(negedge clk);
        chk_cnt++;
        if (Stall !== 1'b0 || ReadData !== {16'h0068, 16'hBEEF})
            $display("FAIL fwd_miss: Stall %b data %h, required 0 0068beef", Stall, ReadData);
        else pass_cnt++;
        tick();
        MemRead = 1'b0;
        wait_empty("fwd");
`else
        begin
            bit stall_ok;
            int n;
            @(negedge clk);
            chk_cnt++;
            if (Stall !== 1'b1) $display("FAIL load_stall: Stall %b, required 1", Stall);
            else pass_cnt++;
            tick();
            DataAdr = 32'h68;
            @(negedge clk);
            chk_cnt++;
            if (Stall !== 1'b1) $display("FAIL load_stall_miss: Stall %b, required 1", Stall);
            else pass_cnt++;
            tick();
            DataAdr  = 32'h60;
            mem_ack  = 1'b1;
            stall_ok = 1'b1;
            n        = 0;
            @(negedge clk);
            while (!Empty && n < 20) begin
                if (Stall !== 1'b1) stall_ok = 1'b0;
                @(negedge clk);
                n++;
            end
            chk_cnt++;
            if (!stall_ok) $display("FAIL load_wait: Stall dropped before Empty, required 1");
            else pass_cnt++;
            chk_cnt++;
            if (Empty !== 1'b1 || Stall !== 1'b0 || ReadData !== {16'h0060, 16'hBEEF})
                $display("FAIL load_after: Empty %b Stall %b data %h, required 1 0 0060beef",
                         Empty, Stall, ReadData);
            else pass_cnt++;
            tick();
            MemRead = 1'b0;
            mem_ack = 1'b0;
            chk_cnt++;
            if (sb.size() != 0) $display("FAIL load_sb: %0d undrained, required 0", sb.size());
            else pass_cnt++;
        end
`endif
    endtask

    task automatic test_random_drain();
        int st;
        int base;
        logic [31:0] a;
        base     = drained;
        rand_ack = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a = $urandom & 32'h0000_0FFF;
            do_store(a, $urandom, st);
            MemWrite = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        @(negedge clk);
        rand_ack = 1'b0;
        tick();
        wait_empty("rand");
        chk_cnt++;
        if (drained - base != 50)
            $display("FAIL rand_count: %0d drained, required 50", drained - base);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        int st;
        bit seen;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) do_store(32'h200 + 32'(i * 4), 32'h5A0 + 32'(i), st);
        MemWrite = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (mem_req !== 1'b1 || Empty !== 1'b0)
            $display("FAIL rst_pre: req %b Empty %b, required 1 0", mem_req, Empty);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        @(negedge clk);
        chk_cnt++;
        if (mem_req !== 1'b0 || Empty !== 1'b1)
            $display("FAIL rst_post: req %b Empty %b, required 0 1", mem_req, Empty);
        else pass_cnt++;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b1;
        seen    = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        chk_cnt++;
        if (seen || Empty !== 1'b1)
            $display("FAIL rst_quiet: req seen %b Empty %b, required 0 1", seen, Empty);
        else pass_cnt++;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full();
        test_forward();
        test_random_drain();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle ARM core's data port and a multi-cycle backing data memory. It accepts word stores from the core in one cycle, queues them in a FIFO and drains them to memory over a req/ack handshake. Loads read the memory's combinational read port, with store-to-load forwarding from the queue. It asserts a stall when it cannot accept the core's current access.

## Interface
- DEPTH, 4: number of queued stores; a power of two, at least 2.
- AW, 32: byte-address width; comparisons use word address [AW-1:2].
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  core store strobe.
- MemRead  in  1  core load strobe; never asserted in the same cycle as MemWrite.
- DataAdr  in  AW  core byte address for the load or store.
- WriteData  in  32  core store data.
- ReadData  out  32  load data to the core (combinational).
- Stall  out  1  the core must hold the current instruction; the access is not taken (combinational).
- Empty  out  1  queue holds no entries (registered).
- mem_req  out  1  drain request.
- mem_addr  out  AW  address of the head entry, with [1:0] forced to 00.
- mem_wdata  out  32  data of the head entry.
- mem_ack  in  1  memory has accepted the head entry; sampled on the clock edge.
- mem_raddr  out  AW  equals DataAdr (pass-through read address).
- mem_rdata  in  32  combinational read data from the backing memory.

## Operation
- The storage is a circular FIFO: DEPTH entries of {word address, data}, with head pointer, tail pointer and count registers of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - Full when count == DEPTH; Empty when count == 0.
- **Push:** on MemWrite & ~Stall, the tail entry is written and the tail and count advance at the edge.
- **Drain FSM:** two states.
  - IDLE: mem_req = 0. Moves to REQ when count != 0.
  - REQ: mem_req = 1; mem_addr and mem_wdata show the head entry and stay stable until acked.
  - On mem_ack in REQ, the head is popped at the edge. The FSM stays in REQ if count after the pop is nonzero, otherwise it returns to IDLE.
  - mem_ack is ignored in IDLE.
- **Simultaneous push and pop:** count is unchanged, both pointers advance, and the FSM stays in REQ.
- **Full:** Stall = MemWrite & full, evaluated on the registered count. A pop in the same cycle does not admit the push; the store is taken on the next cycle.
- **Loads:**
  - ReadData = the data of the youngest queued entry whose word address equals DataAdr[AW-1:2]; mem_rdata if no entry matches.
  - The entry being popped this cycle still counts as queued.
  - A store being pushed this cycle is never forwarded.
- Stores to the same address are not merged; each is drained separately, in program order.
- Reset mid-drain: all queued stores are discarded and mem_req drops immediately. The memory side must tolerate an abandoned request.

## Timing
- Reset values: mem_req 0, Empty 1, Stall 0 (absent MemWrite/MemRead), head, tail and count 0, FSM IDLE. mem_addr and mem_wdata are don't-care while mem_req = 0.
- Push-to-request latency: a store pushed at edge N gives mem_req = 1 in cycle N+1 if the queue was empty.
- Pop: mem_ack high at edge M frees the entry at M. The next entry is presented in cycle M+1 with mem_req still high, so the queue can sustain one drain per cycle.
- Forwarding and Stall are combinational within the access cycle; no load adds latency unless stalled.

## Configuration
- STBUF_FWD_EN defined:
  - Forwarding is enabled as described above.
  - Stall = (MemWrite & full).
- STBUF_FWD_EN undefined:
  - There is no forwarding compare; ReadData = mem_rdata.
  - Stall = (MemWrite & full) | (MemRead & ~Empty): a load waits until the queue has fully drained.

## Test plan
- Reset, then store 7 to 0x64 with mem_ack tied high:
  - mem_req = 1 with mem_addr 0x64 and mem_wdata 7 in the following cycle.
  - Empty = 1 one cycle after the ack.
- With mem_ack held low, issue 5 consecutive stores to 0x00, 0x04, 0x08, 0x0C and 0x10 (DEPTH=4):
  - Stall = 1 on the fifth store.
  - Raise mem_ack for one cycle: the fifth store is taken on the cycle after the ack.
  - The drain order is 0x00, 0x04, 0x08, 0x0C, 0x10.
- With mem_ack low, store 0x11 then 0x22 to 0x60, then load from 0x60:
  - With STBUF_FWD_EN, ReadData = 0x22 with Stall = 0.
  - Without it, Stall = 1 until Empty = 1, then ReadData = mem_rdata.
- Load from 0x68 with the queue holding only 0x60 → ReadData = mem_rdata and Stall = 0 (with the macro defined).
- Drain under a random 30% mem_ack pattern, interleaving 50 stores:
  - The memory receives every store exactly once, in order.
  - mem_addr and mem_wdata never change while mem_req = 1 and mem_ack = 0.
- Assert reset with 3 entries queued and mem_req high → mem_req = 0 and Empty = 1 after the edge, and no further requests occur.
